// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shifter: splits one shift request into passes of 0-3 positions.
// Optional ALU_SHIFT_CLAMP_EN trims over-range amounts (requires N a power of two).
module alu_shift_sequencer #(
    parameter int N  = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  a,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  z
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_work, w_work_nxt;
    logic [N-1:0]  r_z, w_z_nxt;
    logic [N-1:0]  w_shifted;
    logic [1:0]    r_op, w_op_nxt;
    logic [1:0]    w_step;
    logic [AW-1:0] r_rem, w_rem_nxt;
    logic [AW-1:0] w_rem_dec;
    logic [AW-1:0] w_eff;

    // One pass of the barrel step: apply the single-position op s times.
    function automatic logic [N-1:0] shift_step(input logic [N-1:0] v,
                                                input logic [1:0]   sop,
                                                input logic [1:0]   s);
        logic [N-1:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < s) begin
                case (sop)
                    OP_SLL:  r = {r[N-2:0], 1'b0};
                    OP_SRL:  r = {1'b0, r[N-1:1]};
                    OP_SRA:  r = {r[N-1], r[N-1:1]};
                    default: r = {r[0], r[N-1:1]};
                endcase
            end
        end
        return r;
    endfunction

`ifdef ALU_SHIFT_CLAMP_EN
    always_comb begin
        if (op == OP_ROR)
            w_eff = amt & AW'(N - 1);
        else if (int'(amt) >= N)
            w_eff = AW'(N);
        else
            w_eff = amt;
    end
`else
    assign w_eff = amt;
`endif

    always_comb begin
        w_step      = (r_rem > AW'(3)) ? 2'd3 : r_rem[1:0];
        w_shifted   = shift_step(r_work, r_op, w_step);
        w_rem_dec   = r_rem - AW'(w_step);
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        w_z_nxt     = r_z;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_work_nxt = a;
                    w_op_nxt   = op;
                    w_rem_nxt  = w_eff;
                    if (w_eff == '0) begin
                        w_z_nxt     = a;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_work_nxt = w_shifted;
                w_rem_nxt  = w_rem_dec;
                if (w_rem_dec == '0) begin
                    w_z_nxt     = w_shifted;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_op    <= '0;
            r_rem   <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_z     <= w_z_nxt;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign z    = r_z;

endmodule
